// File: rtl/move_pkg.sv
// move_pkg: shared tile codes, FSM state encoding and default widths for the move resolver.
package move_pkg;
  localparam int GRID_W_DEF = 4;
  localparam int TILE_W_DEF = 4;
  localparam logic [TILE_W_DEF-1:0] FLOOR    = 4'd0;
  localparam logic [TILE_W_DEF-1:0] WALL     = 4'd1;
  localparam logic [TILE_W_DEF-1:0] BOX      = 4'd2;
  localparam logic [TILE_W_DEF-1:0] GOAL     = 4'd3;
  localparam logic [TILE_W_DEF-1:0] BOX_GOAL = 4'd4;
  typedef enum logic [2:0] {IDLE, RD_T, RD_B, WR_B, WR_T, ACC, REJ} state_t;
endpackage

// File: rtl/move_resolver_if.sv
// move_resolver_if: move request/response channel and tile-map RAM port.
interface move_req_if #(parameter int GRID_W = 4);
  logic [GRID_W-1:0] player_x, player_y, ask_x, ask_y, goto_x, goto_y;
  logic ask_move, accept_move, reject_move, busy;
  modport master (output player_x, player_y, ask_move, ask_x, ask_y,
                  input accept_move, reject_move, goto_x, goto_y, busy);
  modport slave (input player_x, player_y, ask_move, ask_x, ask_y,
                 output accept_move, reject_move, goto_x, goto_y, busy);
endinterface

interface map_if #(parameter int ADDR_W = 8, parameter int TILE_W = 4);
  logic [ADDR_W-1:0] map_addr;
  logic [TILE_W-1:0] map_rdata, map_wdata;
  logic map_we;
  modport master (output map_addr, map_we, map_wdata, input map_rdata);
  modport slave (input map_addr, map_we, map_wdata, output map_rdata);
endinterface

// File: rtl/move_resolver_step_calc.sv
// step_calc: unit-step legality, beyond-tile coordinates and grid-edge flag for a move.
module step_calc #(parameter int GRID_W = 4) (
  input  logic [GRID_W-1:0] px,
  input  logic [GRID_W-1:0] py,
  input  logic [GRID_W-1:0] ax,
  input  logic [GRID_W-1:0] ay,
  output logic              legal,
  output logic [GRID_W-1:0] bx,
  output logic [GRID_W-1:0] by,
  output logic              oob
);
  localparam logic [GRID_W:0] ONE = 1;
  logic [GRID_W:0] dx, dy, sx, sy;
  logic ux, uy;
  always_comb begin
    dx = {1'b0, ax} - {1'b0, px};
    dy = {1'b0, ay} - {1'b0, py};
    ux = dx == ONE || dx == '1;
    uy = dy == ONE || dy == '1;
    legal = (ux && dy == '0) || (uy && dx == '0);
    sx = {1'b0, ax} + dx;
    sy = {1'b0, ay} + dy;
    bx = sx[GRID_W-1:0];
    by = sy[GRID_W-1:0];
    // a unit step off either edge lands on bit GRID_W of the extended sum
    oob = sx[GRID_W] || sy[GRID_W];
  end
endmodule

// File: rtl/move_resolver.sv
// move_resolver: grants or denies player moves against the tile map, rewriting tiles for box pushes.
module move_resolver
  import move_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int TILE_W = TILE_W_DEF,
  parameter int ADDR_W = 2 * GRID_W
) (
  input logic       clk,
  input logic       rstn,
  move_req_if.slave req,
  map_if.master     map
);
  state_t state_q, state_d;
  logic [GRID_W-1:0] px_q, px_d, py_q, py_d, ax_q, ax_d, ay_q, ay_d;
  logic [GRID_W-1:0] bx, by;
  logic [TILE_W-1:0] t_q, t_d, b_q, b_d;
  logic idle, legal, oob, rd_open, rd_box;
  assign idle = state_q == IDLE;
  assign rd_open = map.map_rdata == TILE_W'(FLOOR) || map.map_rdata == TILE_W'(GOAL);
  assign rd_box = map.map_rdata == TILE_W'(BOX) || map.map_rdata == TILE_W'(BOX_GOAL);
  assign req.busy = !idle;
  // live coordinates feed the calculator in IDLE, captured ones afterwards
  step_calc #(.GRID_W(GRID_W)) u_step (
    .px(idle ? req.player_x : px_q),
    .py(idle ? req.player_y : py_q),
    .ax(idle ? req.ask_x : ax_q),
    .ay(idle ? req.ask_y : ay_q),
    .legal(legal),
    .bx(bx),
    .by(by),
    .oob(oob)
  );
  always_comb begin
    state_d = state_q;
    px_d = px_q;
    py_d = py_q;
    ax_d = ax_q;
    ay_d = ay_q;
    t_d = t_q;
    b_d = b_q;
    map.map_addr = '0;
    map.map_we = 1'b0;
    map.map_wdata = '0;
    req.accept_move = 1'b0;
    req.reject_move = 1'b0;
    req.goto_x = '0;
    req.goto_y = '0;
    unique case (state_q)
      IDLE: if (req.ask_move) begin
        px_d = req.player_x;
        py_d = req.player_y;
        ax_d = req.ask_x;
        ay_d = req.ask_y;
        state_d = legal ? RD_T : REJ;
        map.map_addr = legal ? ADDR_W'({req.ask_y, req.ask_x}) : '0;
      end
      RD_T: begin
        t_d = map.map_rdata;
        state_d = rd_open ? ACC : (rd_box && !oob) ? RD_B : REJ;
        map.map_addr = (rd_box && !oob) ? ADDR_W'({by, bx}) : '0;
      end
      RD_B: begin
        b_d = map.map_rdata;
        state_d = rd_open ? WR_B : REJ;
      end
      WR_B: begin
        map.map_we = 1'b1;
        map.map_addr = ADDR_W'({by, bx});
        map.map_wdata = b_q == TILE_W'(GOAL) ? TILE_W'(BOX_GOAL) : TILE_W'(BOX);
        state_d = WR_T;
      end
      WR_T: begin
        map.map_we = 1'b1;
        map.map_addr = ADDR_W'({ay_q, ax_q});
        map.map_wdata = t_q == TILE_W'(BOX_GOAL) ? TILE_W'(GOAL) : TILE_W'(FLOOR);
        state_d = ACC;
      end
      ACC: begin
        req.accept_move = 1'b1;
        req.goto_x = ax_q;
        req.goto_y = ay_q;
        state_d = IDLE;
      end
      REJ: begin
        req.reject_move = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      px_q <= '0;
      py_q <= '0;
      ax_q <= '0;
      ay_q <= '0;
      t_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      px_q <= px_d;
      py_q <= py_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      t_q <= t_d;
      b_q <= b_d;
    end
  end
endmodule

// File: tb/tb_move_resolver.sv
// tb_move_resolver: directed and randomized move requests checked against a tile-map reference model.
module tb_move_resolver;
  import move_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic load = 1'b0;
  logic [3:0] ram [256];
  logic [3:0] model_map [256];
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  move_req_if #(.GRID_W(4)) rif();
  map_if #(.ADDR_W(8), .TILE_W(4)) mif();
  move_resolver dut (.clk(clk), .rstn(rstn), .req(rif), .map(mif));
  // synchronous map RAM, read-first, bulk-loadable from the model map
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 256; i++) ram[i] <= model_map[i];
    else if (mif.map_we) ram[mif.map_addr] <= mif.map_wdata;
    mif.map_rdata <= ram[mif.map_addr];
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clear_map();
    for (int i = 0; i < 256; i++) model_map[i] = FLOOR;
  endtask
  task automatic set_tile(input int x, input int y, input logic [3:0] t);
    model_map[y * 16 + x] = t;
  endtask
  task automatic load_map();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask
  task automatic check_map(input string tag);
    int d = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model_map[i]) d++;
    chk(tag, d, 0);
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_acc"}, int'(rif.accept_move), 0);
    chk({tag, "_rej"}, int'(rif.reject_move), 0);
    chk({tag, "_busy"}, int'(rif.busy), 0);
    chk({tag, "_we"}, int'(mif.map_we), 0);
    chk({tag, "_addr"}, int'(mif.map_addr), 0);
    chk({tag, "_gx"}, int'(rif.goto_x), 0);
  endtask
  // game rules applied to the model map: returns outcome, latency and write count
  task automatic model_req(input int px, input int py, input int ax, input int ay,
                           output bit acc, output int lat, output int wr);
    int dx, dy, bx, by;
    logic [3:0] t, b;
    dx = ax - px;
    dy = ay - py;
    acc = 0;
    wr = 0;
    lat = 1;
    if (dx * dx + dy * dy != 1) return;
    t = model_map[ay * 16 + ax];
    lat = 2;
    if (t == FLOOR || t == GOAL) begin
      acc = 1;
      return;
    end
    if (t != BOX && t != BOX_GOAL) return;
    bx = ax + dx;
    by = ay + dy;
    if (bx < 0 || bx > 15 || by < 0 || by > 15) return;
    b = model_map[by * 16 + bx];
    lat = 3;
    if (b != FLOOR && b != GOAL) return;
    model_map[by * 16 + bx] = (b == FLOOR) ? BOX : BOX_GOAL;
    model_map[ay * 16 + ax] = (t == BOX) ? FLOOR : GOAL;
    acc = 1;
    lat = 5;
    wr = 2;
  endtask
  task automatic run_req(input string tag, input int px, input int py, input int ax, input int ay,
                         input bit repulse);
    bit exp_acc, got_acc;
    int exp_lat, exp_wr, lat, wr, pulses, gx, gy;
    model_req(px, py, ax, ay, exp_acc, exp_lat, exp_wr);
    lat = 0;
    wr = 0;
    pulses = 0;
    gx = 0;
    gy = 0;
    got_acc = 0;
    @(negedge clk);
    rif.player_x = 4'(px);
    rif.player_y = 4'(py);
    rif.ask_x = 4'(ax);
    rif.ask_y = 4'(ay);
    rif.ask_move = 1'b1;
    @(posedge clk);
    #1;
    rif.ask_move = repulse;
    rif.player_x = 4'($urandom_range(0, 15));
    rif.player_y = 4'($urandom_range(0, 15));
    if (repulse) begin
      rif.ask_x = rif.player_x + 4'd1;
      rif.ask_y = rif.player_y;
    end
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) rif.ask_move = 1'b0;
      if (c == 1) chk({tag, "_busy"}, int'(rif.busy), 1);
      if (rif.accept_move || rif.reject_move) begin
        pulses += (rif.accept_move && rif.reject_move) ? 2 : 1;
        if (lat == 0) begin
          lat = c;
          got_acc = rif.accept_move;
          gx = int'(rif.goto_x);
          gy = int'(rif.goto_y);
        end
      end
      if (mif.map_we) wr++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_acc"}, int'(got_acc), int'(exp_acc));
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_wr"}, wr, exp_wr);
    chk({tag, "_gx"}, gx, exp_acc ? ax : 0);
    chk({tag, "_gy"}, gy, exp_acc ? ay : 0);
    check_map({tag, "_map"});
  endtask
  initial begin
    int px, py, ax, ay, r, dir, found;
    rif.player_x = '0;
    rif.player_y = '0;
    rif.ask_x = '0;
    rif.ask_y = '0;
    rif.ask_move = 1'b0;
    #12;
    check_idle_outputs("rst");
    @(negedge clk) rstn = 1'b1;
    clear_map();
    load_map();
    run_req("free", 3, 3, 4, 3, 0);
    set_tile(3, 2, WALL);
    load_map();
    run_req("wall", 3, 3, 3, 2, 0);
    clear_map();
    set_tile(4, 3, BOX);
    load_map();
    run_req("push", 3, 3, 4, 3, 1);
    clear_map();
    set_tile(4, 3, BOX_GOAL);
    set_tile(5, 3, GOAL);
    load_map();
    run_req("pushgoal", 3, 3, 4, 3, 0);
    clear_map();
    set_tile(15, 3, BOX);
    load_map();
    run_req("edge", 14, 3, 15, 3, 0);
    clear_map();
    set_tile(4, 3, BOX);
    set_tile(5, 3, BOX);
    load_map();
    run_req("boxbox", 3, 3, 4, 3, 0);
    run_req("diag", 3, 3, 4, 4, 0);
    clear_map();
    set_tile(4, 3, BOX);
    load_map();
    @(negedge clk);
    rif.player_x = 4'd3;
    rif.player_y = 4'd3;
    rif.ask_x = 4'd4;
    rif.ask_y = 4'd3;
    rif.ask_move = 1'b1;
    @(posedge clk);
    #1;
    rif.ask_move = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      if (mif.map_we && mif.map_addr == 8'h34) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("midrst_wrt_seen", found, 1);
    rstn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk) rstn = 1'b1;
    set_tile(5, 3, BOX);
    check_map("midrst_map");
    run_req("after_rst", 3, 3, 4, 3, 0);
    run_req("after_rst2", 5, 5, 6, 5, 0);
    for (int ep = 0; ep < 30; ep++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 9);
        model_map[i] = r == 4 ? WALL : r == 5 ? BOX : r == 6 ? GOAL : r == 7 ? BOX_GOAL :
                       r == 9 ? 4'($urandom_range(0, 15)) : FLOOR;
      end
      load_map();
      for (int k = 0; k < 8; k++) begin
        px = $urandom_range(0, 15);
        py = $urandom_range(0, 15);
        r = $urandom_range(0, 9);
        dir = $urandom_range(0, 3);
        ax = r < 8 ? (px + (dir == 0 ? 1 : dir == 1 ? 15 : 0)) % 16 : $urandom_range(0, 15);
        ay = r < 8 ? (py + (dir == 2 ? 1 : dir == 3 ? 15 : 0)) % 16 : $urandom_range(0, 15);
        run_req("rnd", px, py, ax, ay, $urandom_range(0, 3) == 0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
